// File: rtl/serdes_tran_ctrl.sv
// serdes_tran_ctrl: packs radar results from the sys domain into four 16-bit SERDES lanes,
// each fed by its own Gray-pointer async FIFO and a small word-sequencing FSM.

module serdes_async_fifo #(
    parameter int P_W  = 24,
    parameter int P_AW = 14
) (
    input  logic           wclk,
    input  logic           wrst_n,
    input  logic           wen,
    input  logic [P_W-1:0] wdat,
    input  logic           rclk,
    input  logic           rrst_n,
    input  logic           ren,
    output logic [P_W-1:0] rdat,
    output logic           empty
);
    logic [P_W-1:0] mem [2**P_AW];
    logic [P_AW:0] wbin, wbin_nxt, wgray, rbin, rbin_nxt, rgray, wq1, wq2, rq1, rq2;
    logic full, wr, rd;

    // full when the write pointer is exactly one lap ahead of the synchronized read pointer
    assign full     = wgray == {~rq2[P_AW:P_AW-1], rq2[P_AW-2:0]};
    assign empty    = rgray == wq2;
    assign wr       = wen && !full;
    assign rd       = ren && !empty;
    assign wbin_nxt = wbin + (P_AW+1)'(1);
    assign rbin_nxt = rbin + (P_AW+1)'(1);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin  <= '0;
            wgray <= '0;
            rq1   <= '0;
            rq2   <= '0;
        end else begin
            rq1 <= rgray;
            rq2 <= rq1;
            if (wr) begin
                wbin  <= wbin_nxt;
                wgray <= wbin_nxt ^ (wbin_nxt >> 1);
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wr) mem[wbin[P_AW-1:0]] <= wdat;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
        end else begin
            wq1 <= wgray;
            wq2 <= wq1;
            if (rd) begin
                rbin  <= rbin_nxt;
                rgray <= rbin_nxt ^ (rbin_nxt >> 1);
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rd) rdat <= mem[rbin[P_AW-1:0]];
    end
endmodule

module serdes_tx_lane #(
    parameter int          P_W         = 24,
    parameter int          P_AW        = 14,
    parameter bit          P_TRIPLE    = 1'b0,
    parameter logic [15:0] P_IDLE_WORD = 16'h50BC,
    parameter logic [7:0]  P_SOF_K     = 8'hFB
) (
    input  logic           wclk,
    input  logic           wrst_n,
    input  logic           wen,
    input  logic [P_W-1:0] wdat,
    input  logic           rclk,
    input  logic           rrst_n,
    output logic           is_k,
    output logic [15:0]    dat
);
    typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;
    state_t state, state_nxt;
    logic pop, empty;
    logic [P_W-1:0] d;
    logic [23:0] energy;
    logic [12:0] range_bin;

    assign energy    = d[P_W-1 -: 24];
    assign range_bin = d[12:0];

    serdes_async_fifo #(.P_W(P_W), .P_AW(P_AW)) u_fifo (
        .wclk(wclk), .wrst_n(wrst_n), .wen(wen), .wdat(wdat),
        .rclk(rclk), .rrst_n(rrst_n), .ren(pop), .rdat(d), .empty(empty)
    );

    // popping on the last word of a sample lets the next one start with no idle gap
    always_comb begin
        pop       = !empty && (state == S_IDLE || (state == S_W1 && !P_TRIPLE) || state == S_W2);
        state_nxt = pop ? S_W0 : state == S_W0 ? S_W1 : (state == S_W1 && P_TRIPLE) ? S_W2 : S_IDLE;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            is_k <= 1'b1;
            dat  <= P_IDLE_WORD;
        end else begin
            is_k <= state == S_IDLE || state == S_W0;
            dat  <= state == S_IDLE ? P_IDLE_WORD :
                    state == S_W0   ? {energy[23:16], P_SOF_K} :
                    state == S_W1   ? energy[15:0] : {3'b000, range_bin};
        end
    end
endmodule

module serdes_tran_ctrl #(
    parameter int          P_FIFO_AW   = 14,
    parameter logic [15:0] P_IDLE_WORD = 16'h50BC,
    parameter logic [7:0]  P_SOF_K     = 8'hFB
) (
    input  logic        I_rst_n,
    input  logic        I_sys_clk,
    input  logic        I_M420_result_ena,
    input  logic [23:0] I_M420_i_result_dat,
    input  logic [23:0] I_M420_q_result_dat,
    input  logic        I_s_target_ena,
    input  logic [23:0] I_s_target_energy,
    input  logic        I_target_ena,
    input  logic [23:0] I_target_energy,
    input  logic [12:0] I_target_range,
    input  logic        I_tx_master_clk,
    output logic        O_tx1_is_k,
    output logic [15:0] O_tx1_serdes_dat,
    output logic        O_tx2_is_k,
    output logic [15:0] O_tx2_serdes_dat,
    output logic        O_tx3_is_k,
    output logic [15:0] O_tx3_serdes_dat,
    output logic        O_tx4_is_k,
    output logic [15:0] O_tx4_serdes_dat
);
    logic [1:0] rst_sync;
    logic       tx_rst_n;

    // tx-domain reset asserts with I_rst_n but releases on the tx clock
    always_ff @(posedge I_tx_master_clk or negedge I_rst_n) begin
        if (!I_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign tx_rst_n = rst_sync[1];

    serdes_tx_lane #(.P_W(24), .P_AW(P_FIFO_AW), .P_TRIPLE(1'b0), .P_IDLE_WORD(P_IDLE_WORD), .P_SOF_K(P_SOF_K)) u_lane1 (
        .wclk(I_sys_clk), .wrst_n(I_rst_n), .wen(I_M420_result_ena), .wdat(I_M420_i_result_dat),
        .rclk(I_tx_master_clk), .rrst_n(tx_rst_n), .is_k(O_tx1_is_k), .dat(O_tx1_serdes_dat)
    );

    serdes_tx_lane #(.P_W(24), .P_AW(P_FIFO_AW), .P_TRIPLE(1'b0), .P_IDLE_WORD(P_IDLE_WORD), .P_SOF_K(P_SOF_K)) u_lane2 (
        .wclk(I_sys_clk), .wrst_n(I_rst_n), .wen(I_M420_result_ena), .wdat(I_M420_q_result_dat),
        .rclk(I_tx_master_clk), .rrst_n(tx_rst_n), .is_k(O_tx2_is_k), .dat(O_tx2_serdes_dat)
    );

    serdes_tx_lane #(.P_W(37), .P_AW(P_FIFO_AW), .P_TRIPLE(1'b1), .P_IDLE_WORD(P_IDLE_WORD), .P_SOF_K(P_SOF_K)) u_lane3 (
        .wclk(I_sys_clk), .wrst_n(I_rst_n), .wen(I_target_ena), .wdat({I_target_energy, I_target_range}),
        .rclk(I_tx_master_clk), .rrst_n(tx_rst_n), .is_k(O_tx3_is_k), .dat(O_tx3_serdes_dat)
    );

    serdes_tx_lane #(.P_W(24), .P_AW(P_FIFO_AW), .P_TRIPLE(1'b0), .P_IDLE_WORD(P_IDLE_WORD), .P_SOF_K(P_SOF_K)) u_lane4 (
        .wclk(I_sys_clk), .wrst_n(I_rst_n), .wen(I_s_target_ena), .wdat(I_s_target_energy),
        .rclk(I_tx_master_clk), .rrst_n(tx_rst_n), .is_k(O_tx4_is_k), .dat(O_tx4_serdes_dat)
    );
endmodule

// File: tb/tb_serdes_tran_ctrl.sv
// tb_serdes_tran_ctrl: scoreboard bench; stimulus queues whole samples per lane, monitors
// reassemble lane words into samples and compare, tolerating drops only in the overflow phase.
`timescale 1ns/100ps
module tb_serdes_tran_ctrl;
    localparam logic [15:0] IDLE = 16'h50BC;
    localparam logic [7:0]  SOF  = 8'hFB;
    localparam int          DEPTH = 16;

    logic        rst_n = 1'b1, sys_clk = 1'b0, tx_clk = 1'b0;
    logic        m_ena = 1'b0, t_ena = 1'b0, s_ena = 1'b0;
    logic [23:0] i_dat = '0, q_dat = '0, t_energy = '0, s_energy = '0;
    logic [12:0] t_range = '0;
    logic        is_k [4];
    logic [15:0] dat [4];

    int checks = 0, failures = 0;
    logic [36:0] exp_q [4][$];
    bit allow_drop [4];
    int consumed [4];
    int rcvd [4];

    always #2.5 sys_clk = ~sys_clk;
    always #3.2 tx_clk = ~tx_clk;

    serdes_tran_ctrl #(.P_FIFO_AW(4)) dut (
        .I_rst_n(rst_n), .I_sys_clk(sys_clk),
        .I_M420_result_ena(m_ena), .I_M420_i_result_dat(i_dat), .I_M420_q_result_dat(q_dat),
        .I_s_target_ena(s_ena), .I_s_target_energy(s_energy),
        .I_target_ena(t_ena), .I_target_energy(t_energy), .I_target_range(t_range),
        .I_tx_master_clk(tx_clk),
        .O_tx1_is_k(is_k[0]), .O_tx1_serdes_dat(dat[0]),
        .O_tx2_is_k(is_k[1]), .O_tx2_serdes_dat(dat[1]),
        .O_tx3_is_k(is_k[2]), .O_tx3_serdes_dat(dat[2]),
        .O_tx4_is_k(is_k[3]), .O_tx4_serdes_dat(dat[3])
    );

    task automatic check(input string name, input logic [36:0] got, input logic [36:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic complete(input int ln, input logic [36:0] got);
        while (allow_drop[ln] && exp_q[ln].size() > 0 && exp_q[ln][0] != got) begin
            check($sformatf("ovf_keep_first_l%0d", ln + 1), 37'(consumed[ln] >= DEPTH), 37'd1);
            void'(exp_q[ln].pop_front());
            consumed[ln]++;
        end
        if (exp_q[ln].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample_l%0d got=%h want=none", ln + 1, got);
        end else begin
            consumed[ln]++;
            rcvd[ln]++;
            check($sformatf("sample_l%0d", ln + 1), got, exp_q[ln].pop_front());
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : mon
        initial begin
            int phase = 0;
            logic [7:0]  hi = '0;
            logic [15:0] lo = '0;
            forever begin
                @(negedge tx_clk);
                if (!rst_n) begin
                    phase = 0;
                    check($sformatf("rst_idle_l%0d", g + 1), {20'd0, is_k[g], dat[g]}, {20'd0, 1'b1, IDLE});
                end else if (phase == 0) begin
                    check($sformatf("word_l%0d", g + 1), 37'(is_k[g] && (dat[g] == IDLE || dat[g][7:0] == SOF)), 37'd1);
                    if (is_k[g] && dat[g][7:0] == SOF) begin
                        hi = dat[g][15:8];
                        phase = 1;
                    end
                end else if (phase == 1) begin
                    check($sformatf("w1_is_k_l%0d", g + 1), 37'(is_k[g]), 37'd0);
                    lo = dat[g];
                    if (g == 2) phase = 2;
                    else begin
                        complete(g, {13'd0, hi, lo});
                        phase = 0;
                    end
                end else begin
                    check("w2_hdr_l3", 37'({is_k[g], dat[g][15:13]}), 37'd0);
                    complete(g, {hi, lo, dat[g][12:0]});
                    phase = 0;
                end
            end
        end
    end

    task automatic drive(input bit m, input logic [23:0] i, input logic [23:0] q,
                         input bit t, input logic [23:0] te, input logic [12:0] tr,
                         input bit s, input logic [23:0] se);
        @(negedge sys_clk);
        m_ena = m; i_dat = i; q_dat = q;
        t_ena = t; t_energy = te; t_range = tr;
        s_ena = s; s_energy = se;
        if (m) begin
            exp_q[0].push_back({13'd0, i});
            exp_q[1].push_back({13'd0, q});
        end
        if (t) exp_q[2].push_back({te, tr});
        if (s) exp_q[3].push_back({13'd0, se});
    endtask

    task automatic quiet();
        @(negedge sys_clk);
        m_ena = 1'b0; t_ena = 1'b0; s_ena = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (n < budget && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
            @(negedge tx_clk);
            n++;
        end
        check(name, 37'(n < budget), 37'd1);
        repeat (8) @(negedge tx_clk);
    endtask

    task automatic check_idle(input string name);
        for (int l = 0; l < 4; l++)
            check($sformatf("%s_l%0d", name, l + 1), {20'd0, is_k[l], dat[l]}, {20'd0, 1'b1, IDLE});
    endtask

    initial begin
        int lat;
        bit found, prev;
        #1 rst_n = 1'b0;
        #10 check_idle("reset");
        #10;
        @(negedge sys_clk) rst_n = 1'b1;
        repeat (10) @(negedge tx_clk);
        check_idle("after_reset");

        drive(0, 0, 0, 0, 0, 0, 1, 24'hABCDEF);
        @(posedge sys_clk);
        fork quiet(); join_none
        lat = 0;
        do begin
            @(posedge tx_clk);
            lat++;
            #0.5;
        end while (lat < 20 && !(is_k[3] && dat[3] == {8'hAB, SOF}));
        check("latency_3_to_8", 37'(lat >= 3 && lat <= 8), 37'd1);
        wait_drain("drain_latency", 200);

        for (int k = 0; k < 12; k++) drive(1, 24'(k), 24'(k), 0, 0, 0, 0, 0);
        quiet();
        wait_drain("drain_m420", 400);
        for (int k = 16384; k < 16396; k++) drive(0, 0, 0, 1, 24'(k), 13'(k), 0, 0);
        quiet();
        wait_drain("drain_target", 400);
        for (int k = 18420; k < 18432; k++) drive(0, 0, 0, 0, 0, 0, 1, 24'(k));
        quiet();
        wait_drain("drain_secondary", 400);
        check_idle("after_bursts");

        drive(1, 24'hFFFFFF, 24'h000000, 1, 24'hFFFFFF, 13'h1FFF, 1, 24'h800000);
        for (int c = 0; c < 1500; c++)
            drive($urandom_range(9) == 0, 24'($urandom), 24'($urandom),
                  $urandom_range(9) == 0, 24'($urandom), 13'($urandom),
                  $urandom_range(9) == 0, 24'($urandom));
        quiet();
        wait_drain("drain_random", 4000);

        for (int l = 0; l < 4; l++) begin
            allow_drop[l] = 1'b1;
            consumed[l] = 0;
            rcvd[l] = 0;
        end
        for (int k = 0; k < 40; k++)
            drive(1, 24'h100 + 24'(k), 24'h200 + 24'(k), 1, 24'h300 + 24'(k), 13'(k), 1, 24'h400 + 24'(k));
        quiet();
        repeat (400) @(negedge tx_clk);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("ovf_min_rcvd_l%0d", l + 1), 37'(rcvd[l] >= DEPTH), 37'd1);
            exp_q[l].delete();
            allow_drop[l] = 1'b0;
        end
        check("ovf_lane3_dropped", 37'(rcvd[2] < 40), 37'd1);
        check_idle("after_overflow");

        for (int k = 0; k < 6; k++) drive(0, 0, 0, 1, 24'h500 + 24'(k), 13'(k), 0, 0);
        quiet();
        found = 1'b0;
        prev = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge tx_clk);
            found = prev && !is_k[2];
            prev = is_k[2] && dat[2][7:0] == SOF;
        end
        check("lane3_w1_seen", 37'(found), 37'd1);
        #1 rst_n = 1'b0;
        #0.5 check_idle("mid_reset");
        for (int l = 0; l < 4; l++) exp_q[l].delete();
        #12;
        @(negedge sys_clk) rst_n = 1'b1;
        repeat (30) @(negedge tx_clk);
        check_idle("post_mid_reset");
        drive(0, 0, 0, 1, 24'h123456, 13'h0ABC, 0, 0);
        quiet();
        wait_drain("drain_post_reset", 200);
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serdes_tran_ctrl.md
Name: serdes_tran_ctrl

Overview:
- Packs radar processing results from the I_sys_clk domain into 16-bit SERDES transmit words in the I_tx_master_clk domain, one lane per stream.
- Streams and lanes:
  - Lane 1: M420 I accumulation results.
  - Lane 2: M420 Q accumulation results.
  - Lane 3: CFAR targets (energy and range).
  - Lane 4: secondary-target energies.
- Each lane has its own asynchronous FIFO that absorbs input bursts arriving faster than the line rate; the lane sends comma idles when it has nothing to send.

Parameters:
- P_FIFO_AW, 14, FIFO address width per lane (depth 2^P_FIFO_AW = 16384 entries).
- P_IDLE_WORD, 16'h50BC, idle word (low byte K28.5 = 8'hBC), sent with is_k=1.
- P_SOF_K, 8'hFB, start-of-sample K character (K27.7) placed in the low byte.

Ports:
- I_rst_n  in  1  asynchronous active-low reset, shared by both domains.
- I_sys_clk  in  1  input-side clock (200 MHz nominal).
- I_M420_result_ena  in  1  I/Q sample valid, one sample per cycle.
- I_M420_i_result_dat  in  24  I sample.
- I_M420_q_result_dat  in  24  Q sample.
- I_s_target_ena  in  1  secondary-target valid.
- I_s_target_energy  in  24  secondary-target energy.
- I_target_ena  in  1  target valid.
- I_target_energy  in  24  target energy.
- I_target_range  in  13  target range bin.
- I_tx_master_clk  in  1  SERDES transmit clock (156.25 MHz nominal, asynchronous to I_sys_clk).
- O_tx1_is_k / O_tx1_serdes_dat  out  1 / 16  lane 1 (I data).
- O_tx2_is_k / O_tx2_serdes_dat  out  1 / 16  lane 2 (Q data).
- O_tx3_is_k / O_tx3_serdes_dat  out  1 / 16  lane 3 (targets).
- O_tx4_is_k / O_tx4_serdes_dat  out  1 / 16  lane 4 (secondary targets).

Behaviour:
- Reset:
  - Reset is I_rst_n, asynchronous, active-low. The DUT clocks on I_sys_clk on the write side.
  - The tx domain takes I_rst_n through a 2-flop synchronizer: assert asynchronously, release synchronously.
  - While in reset, every lane outputs is_k=1 and dat=P_IDLE_WORD. All FIFOs are emptied. Reset mid-transfer aborts any partial sample; the lane returns to idle.
- Write side (I_sys_clk):
  - Any ena=1 cycle writes one entry into the matching FIFO.
  - M420 ena writes I into FIFO1 and Q into FIFO2 in the same cycle.
  - FIFO3 entries are 37 bits, {energy, range}.
  - If a FIFO is full, the sample is dropped and the FIFO contents are unchanged. There is no backpressure.
- CDC:
  - Each FIFO uses Gray-coded pointers with 2-flop synchronizers in each direction.
  - Full and empty are computed conservatively; no data loss or duplication while not full.
- Read side, per lane (I_tx_master_clk): state machine IDLE -> W0 -> W1 [-> W2 on lane 3] -> IDLE, or -> W0 directly if the FIFO is non-empty. Samples are sent back-to-back with no idle gap.
  - IDLE: output P_IDLE_WORD with is_k=1. When the FIFO is non-empty, pop one entry and go to W0 on the next cycle.
  - W0: output is_k=1, dat={d[23:16], P_SOF_K}.
  - W1: output is_k=0, dat=d[15:0].
  - W2 (lane 3 only): output is_k=0, dat={3'b000, range[12:0]}.
- All outputs are registered.
- Latency: the W0 word appears between 3 and 8 I_tx_master_clk cycles after the I_sys_clk edge that wrote into an empty FIFO.
- Ordering: FIFO order is preserved. Lanes are independent, and no cross-lane alignment is guaranteed.
- Sustained throughput:
  - Lanes 1, 2, 4: one sample per 2 tx cycles.
  - Lane 3: one sample per 3 tx cycles.
- Boundaries:
  - Empty FIFO: idles only.
  - Full FIFO: drop the newest sample.
  - Pointers wrap modulo 2^(P_FIFO_AW+1).
  - Simultaneous enables on different streams are all accepted.

Test Plan:
- Reset: hold I_rst_n=0 for 10 ns -> all four lanes is_k=1, dat=16'h50BC; FIFOs empty after release.
- M420 burst: ena=1 for 16384 consecutive cycles with I=Q={9'd0,n}, n=0..16383.
  - Lanes 1 and 2 each emit 16384 pairs: {8'h00,8'hFB}/K followed by 16'(n), n ascending, no loss.
  - Each lane then returns to 16'h50BC.
- Target burst: 1024 cycles, energy={9'd0,n}, range=n[12:0], n=16384..17407.
  - Lane 3 emits triples, e.g. for n=16384: {8'h00,8'hFB}/K, 16'h4000, 16'h0000.
  - Lanes 1, 2 and 4 are unaffected.
- Secondary burst: 1024 cycles, energy n=17408..18431 -> lane 4 emits pairs ending with 16'h47FF, then idles.
- Overflow: with P_FIFO_AW=4, write 40 samples at 1 per cycle -> first samples output in order, excess dropped, no duplicates, lane recovers to idle.
- Reset mid-transfer: assert I_rst_n during a lane 3 W1 cycle -> outputs return to 16'h50BC/K immediately; no stale data after release.
